// File: rtl/shader_pkg.sv
// shader_pkg: shared Q-format constants and gradient FSM state type
package shader_pkg;
  localparam int Q7_FRAC = 7;
  localparam int Q14_FRAC = 14;
  localparam logic [15:0] GRAD_ONE = 16'h4000;
  localparam logic [15:0] GRAD_SAT = 16'h7FFF;
  typedef enum logic [2:0] {IDLE, SETUP, DIV, FIX, DONE} gradient_state_t;
endpackage

// File: rtl/gradient_calc_if.sv
// gradient_calc_if: start/done level handshake with Q.7 operands in and Q.14 gradient out
interface gradient_calc_if;
  logic start;
  logic [15:0] cur;
  logic [15:0] lo;
  logic [15:0] hi;
  logic busy;
  logic done;
  logic [15:0] gradient;
  modport master (output start, cur, lo, hi, input busy, done, gradient);
  modport slave (input start, cur, lo, hi, output busy, done, gradient);
endinterface

// File: rtl/gradient_calc_udiv.sv
// frac_udiv: restoring divider giving q = floor(d * 2^GRAD_FRAC / v) for d < 2v, one bit per cycle after go
module frac_udiv #(
  parameter int GRAD_FRAC = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [16:0]          d,
  input  logic [16:0]          v,
  output logic [GRAD_FRAC:0]   q,
  output logic                 valid
);
  localparam int KW = $clog2(GRAD_FRAC + 1);
  logic [16:0] r_q, r_d;
  logic [GRAD_FRAC:0] q_q, q_d, q_bit;
  logic [KW-1:0] k_q, k_d;
  logic act_q, act_d;
  logic [17:0] trial, diff;
  logic ge;
  always_comb begin
    trial = (k_q == '0) ? {1'b0, d} : {r_q, 1'b0};
    diff  = trial - {1'b0, v};
    ge    = trial >= {1'b0, v};
    q_bit = (GRAD_FRAC + 1)'(ge) << (KW'(GRAD_FRAC) - k_q);
    r_d   = go ? '0 : act_q ? (ge ? diff[16:0] : trial[16:0]) : r_q;
    q_d   = go ? '0 : act_q ? (q_q | q_bit) : q_q;
    k_d   = go ? '0 : act_q ? k_q + 1'b1 : k_q;
    act_d = go | (act_q & (k_q != KW'(GRAD_FRAC)));
    valid = act_q & (k_q == KW'(GRAD_FRAC));
    q     = q_q | q_bit;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= '0;
      q_q   <= '0;
      k_q   <= '0;
      act_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      q_q   <= q_d;
      k_q   <= k_d;
      act_q <= act_d;
    end
  end
endmodule

// File: rtl/gradient_calc.sv
// gradient_calc: signed Q.14 gradient (cur-lo)/(hi-lo) from Q.7 coordinates over a start/done handshake
module gradient_calc
  import shader_pkg::*;
#(
  parameter int GRAD_FRAC = 14
) (
  input  logic             clk,
  input  logic             reset,
  gradient_calc_if.slave   bus
);
  gradient_state_t state_q, state_d;
  logic [15:0] cur_q, cur_d, lo_q, lo_d, hi_q, hi_d;
  logic [15:0] mag_q, mag_d, grad_q, grad_d;
  logic neg_q, neg_d, done_q, done_d;
  logic [16:0] num, den, abs_num, abs_den;
  logic sat, div_go, div_valid;
  logic [GRAD_FRAC:0] div_q;
  always_comb begin
    num     = {cur_q[15], cur_q} - {lo_q[15], lo_q};
    den     = {hi_q[15], hi_q} - {lo_q[15], lo_q};
    abs_num = num[16] ? -num : num;
    abs_den = den[16] ? -den : den;
    sat     = {1'b0, abs_num} >= {abs_den, 1'b0};
    div_go  = (state_q == SETUP) & (abs_den != '0) & ~sat;
  end
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    grad_d  = grad_q;
    done_d  = done_q;
    case (state_q)
      IDLE: if (bus.start) begin
        cur_d   = bus.cur;
        lo_d    = bus.lo;
        hi_d    = bus.hi;
        state_d = SETUP;
      end
      SETUP: begin
        neg_d   = num[16] ^ den[16];
        state_d = div_go ? DIV : FIX;
        if (abs_den == '0) begin
          mag_d = GRAD_ONE;
          neg_d = 1'b0;
        end else if (sat) mag_d = GRAD_SAT;
      end
      DIV: if (div_valid) begin
        mag_d   = 16'(div_q);
        state_d = FIX;
      end
      FIX: begin
        grad_d  = neg_q ? -mag_q : mag_q;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: if (!bus.start) begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      grad_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      grad_q  <= grad_d;
      done_q  <= done_d;
    end
  end
  frac_udiv #(.GRAD_FRAC(GRAD_FRAC)) u_div (
    .clk   (clk),
    .reset (reset),
    .go    (div_go),
    .d     (abs_num),
    .v     (abs_den),
    .q     (div_q),
    .valid (div_valid)
  );
  assign bus.busy     = (state_q == SETUP) | (state_q == DIV) | (state_q == FIX);
  assign bus.done     = done_q;
  assign bus.gradient = grad_q;
endmodule

// File: tb/tb_gradient_calc.sv
// tb_gradient_calc: table vectors, handshake/reset sequences and random operands against an arithmetic model
module tb_gradient_calc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  gradient_calc_if bus ();
  gradient_calc dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] c, l, h, g;
    int lat;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  function automatic void model(input logic [15:0] c, l, h, output logic [15:0] g, output int lat);
    longint num, den, an, ad, m;
    bit neg;
    num = longint'($signed(c)) - longint'($signed(l));
    den = longint'($signed(h)) - longint'($signed(l));
    an  = num < 0 ? -num : num;
    ad  = den < 0 ? -den : den;
    neg = (num < 0) != (den < 0);
    if (ad == 0) begin
      m = 16384; neg = 0; lat = 2;
    end else if (an >= 2 * ad) begin
      m = 32767; lat = 2;
    end else begin
      m = (an * 16384) / ad; lat = 17;
    end
    g = 16'(neg ? -m : m);
  endfunction
  task automatic run_op(input logic [15:0] c, l, h, eg, input int el, input int drop_at, input int hold);
    int cnt = 0;
    bit busy_ok = 1;
    @(negedge clk);
    bus.cur = c; bus.lo = l; bus.hi = h; bus.start = 1'b1;
    @(negedge clk);
    bus.cur = 16'($urandom); bus.lo = 16'($urandom); bus.hi = 16'($urandom);
    while (!bus.done && cnt < 40) begin
      if (!bus.busy) busy_ok = 0;
      if (cnt == drop_at) bus.start = 1'b0;
      @(negedge clk);
      cnt++;
    end
    chk("latency", cnt, el);
    chk("gradient", bus.gradient, eg);
    chk("busy_during", 32'(busy_ok), 1);
    chk("busy_at_done", bus.busy, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("done_hold", bus.done, 1);
      chk("grad_hold", bus.gradient, eg);
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("done_drop", bus.done, 0);
    chk("grad_keep", bus.gradient, eg);
  endtask
  initial begin
    logic [15:0] c, l, h, g;
    int lat;
    tbl[0] = '{16'h0A00, 16'h0500, 16'h0F00, 16'h2000, 17};
    tbl[1] = '{16'h1234, 16'h0800, 16'h0800, 16'h4000, 2};
    tbl[2] = '{16'h0F00, 16'h0500, 16'h0F00, 16'h4000, 17};
    tbl[3] = '{16'h0300, 16'h0500, 16'h0F00, 16'hF334, 17};
    tbl[4] = '{16'h0A00, 16'h0F00, 16'h0500, 16'h2000, 17};
    tbl[5] = '{16'h2000, 16'h0000, 16'h0100, 16'h7FFF, 2};
    tbl[6] = '{16'hE000, 16'h0000, 16'h0100, 16'h8001, 2};
    tbl[7] = '{16'h01FF, 16'h0000, 16'h0100, 16'h7FC0, 17};
    tbl[8] = '{16'h0200, 16'h0000, 16'h0100, 16'h7FFF, 2};
    tbl[9] = '{16'h0500, 16'h0500, 16'hFB00, 16'h0000, 17};
    bus.start = 1'b0; bus.cur = '0; bus.lo = '0; bus.hi = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grad", bus.gradient, 0);
    reset = 1'b0;
    foreach (tbl[i]) run_op(tbl[i].c, tbl[i].l, tbl[i].h, tbl[i].g, tbl[i].lat, -1, 0);
    run_op(16'h0A00, 16'h0500, 16'h0F00, 16'h2000, 17, -1, 5);
    run_op(16'h0300, 16'h0500, 16'h0F00, 16'hF334, 17, -1, 0);
    run_op(16'h0A00, 16'h0F00, 16'h0500, 16'h2000, 17, 4, 0);
    @(negedge clk);
    bus.cur = 16'h0300; bus.lo = 16'h0500; bus.hi = 16'h0F00; bus.start = 1'b1;
    repeat (8) @(negedge clk);
    reset = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    chk("midrst_done", bus.done, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_grad", bus.gradient, 0);
    reset = 1'b0;
    run_op(16'h0300, 16'h0500, 16'h0F00, 16'hF334, 17, -1, 0);
    for (int i = 0; i < 60; i++) begin
      int mode = int'($urandom_range(0, 3));
      l = 16'($urandom);
      c = 16'($urandom);
      h = 16'($urandom);
      if (mode == 1) h = l;
      else if (mode == 2) begin
        h = l + 16'($urandom_range(0, 1024)) - 16'd512;
        c = l + 16'($urandom_range(0, 2048)) - 16'd1024;
      end else if (mode == 3) begin
        h = l + 16'($urandom_range(1, 4000));
        c = l + 16'($urandom_range(0, 4000));
      end
      model(c, l, h, g, lat);
      run_op(c, l, h, g, lat, -1, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
